// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU / display fetcher) arbiter and address decoder for the data RAM and display register.
// Build option: define ARB_CPU_PRIO_EN for fixed CPU priority; the default is round-robin.
module mem_bus_arbiter #(
  parameter int RAM_AW  = 14,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ack,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic [31:0]       m1_addr,
  output logic              m1_ack,
  output logic [31:0]       m1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              disp_we,
  output logic [31:0]       disp_data,
  output logic              bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {KIND_RAM, KIND_DISP, KIND_ERR} kind_t;

  localparam int            CW       = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RAM_LAT - 1);

  state_t        state_reg;
  kind_t         kind_reg;
  logic          grant_reg;
  logic          we_reg;
  logic          last_grant_reg;
  logic [CW-1:0] cnt_reg;

  logic          grant_next;
  logic          we_next;
  logic [31:0]   addr_next;
  kind_t         kind_next;

  always_comb begin
`ifdef ARB_CPU_PRIO_EN
    grant_next = ~m0_req;
`else
    grant_next = (m0_req && m1_req) ? ~last_grant_reg : m1_req;
`endif
    addr_next = grant_next ? m1_addr : m0_addr;
    // The fetcher has no write path, so a granted M1 is always a read.
    we_next   = ~grant_next & m0_we;
    if (addr_next[31:16] == 16'h0000)
      kind_next = KIND_RAM;
    else if (addr_next[31:2] == 30'h0000_4000)
      kind_next = KIND_DISP;
    else
      kind_next = KIND_ERR;
  end

  // Word accesses only: the byte offset plays no part in decode.
  logic unused_byte_offset;
  assign unused_byte_offset = ^addr_next[1:0];
`ifdef ARB_CPU_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      kind_reg       <= KIND_RAM;
      grant_reg      <= 1'b0;
      we_reg         <= 1'b0;
      last_grant_reg <= 1'b1;
      cnt_reg        <= '0;
      m0_ack         <= 1'b0;
      m0_rdata       <= '0;
      m1_ack         <= 1'b0;
      m1_rdata       <= '0;
      ram_en         <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      disp_we        <= 1'b0;
      disp_data      <= '0;
      bus_err        <= 1'b0;
    end else begin
      ram_en  <= 1'b0;
      ram_we  <= 1'b0;
      disp_we <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            grant_reg <= grant_next;
            we_reg    <= we_next;
            kind_reg  <= kind_next;
            state_reg <= S_ACCESS;
            // Strobes are registered here so they are visible during ACCESS.
            if (kind_next == KIND_RAM) begin
              ram_en    <= 1'b1;
              ram_we    <= we_next;
              ram_addr  <= addr_next[RAM_AW+1:2];
              ram_wdata <= m0_wdata;
            end
            if (kind_next == KIND_DISP && we_next) begin
              disp_we   <= 1'b1;
              disp_data <= m0_wdata;
            end
          end
        end
        S_ACCESS: begin
          cnt_reg <= '0;
          if (kind_reg == KIND_RAM && !we_reg) begin
            state_reg <= S_WAIT;
          end else begin
            state_reg <= S_RESP;
            m0_ack    <= ~grant_reg;
            m1_ack    <= grant_reg;
            bus_err   <= (kind_reg == KIND_ERR);
          end
        end
        S_WAIT: begin
          if (cnt_reg == CNT_LAST) begin
            state_reg <= S_RESP;
            m0_ack    <= ~grant_reg;
            m1_ack    <= grant_reg;
            if (grant_reg)
              m1_rdata <= ram_rdata;
            else
              m0_rdata <= ram_rdata;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        S_RESP: begin
          m0_ack         <= 1'b0;
          m1_ack         <= 1'b0;
          m0_rdata       <= '0;
          m1_rdata       <= '0;
          bus_err        <= 1'b0;
          last_grant_reg <= grant_reg;
          state_reg      <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level model with per-cycle checking plus directed literal checks.
module tb_mem_bus_arbiter;
  localparam int LAT = 2;
  localparam int AW  = 14;

  logic clk = 1'b0;
  logic rst_n;
  logic m0_req, m0_we, m1_req;
  logic [31:0] m0_addr, m0_wdata, m1_addr;
  logic m0_ack, m1_ack, ram_en, ram_we, disp_we, bus_err;
  logic [31:0] m0_rdata, m1_rdata, ram_wdata, ram_rdata, disp_data;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.RAM_AW(AW), .RAM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .disp_we(disp_we), .disp_data(disp_data), .bus_err(bus_err)
  );

  // RAM device: read data appears exactly LAT cycles after ram_en, junk otherwise.
  logic [31:0] ram_mem [0:(1<<AW)-1];
  logic [31:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (ram_en && ram_we) ram_mem[ram_addr] <= ram_wdata;
    rd_pipe[0] <= (ram_en && !ram_we) ? ram_mem[ram_addr] : 32'h5A5A_5A5A;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[LAT-1];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic any_out;
  assign any_out = |{m0_ack, m0_rdata, m1_ack, m1_rdata, ram_en, ram_we, ram_addr,
                     ram_wdata, disp_we, disp_data, bus_err};

  // Model: expected outputs scheduled per cycle from transaction rules.
  typedef struct packed {
    bit          ram_en;
    bit          ram_we;
    bit [AW-1:0] ram_addr;
    bit [31:0]   ram_wdata;
    bit          disp_we;
    bit [31:0]   disp_data;
    bit          ack0;
    bit          ack1;
    bit          berr;
    bit [31:0]   rdata;
  } exp_t;

  exp_t        sched [64];
  logic [31:0] mdl_mem [int];
  int          cyc = 0;
  int          free_at = 0;
  bit          mdl_last = 1'b1;
  bit          pend_valid = 1'b0;
  bit          pend_g;
  int          pend_cyc;
  bit          mg, mw, is_ram, is_disp;
  logic [31:0] ma, mrd;
  int          mlat, widx;

  always @(posedge clk) begin
    sched[cyc % 64] = '0;
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) sched[i] = '0;
      free_at    = cyc + 1;
      mdl_last   = 1'b1;
      pend_valid = 1'b0;
    end else begin
      if (pend_valid && cyc == pend_cyc) begin
        mdl_last   = pend_g;
        pend_valid = 1'b0;
      end
      if (cyc >= free_at && (m0_req || m1_req)) begin
`ifdef ARB_CPU_PRIO_EN
        mg = (m0_req && m1_req) ? 1'b0 : m1_req;
`else
        mg = (m0_req && m1_req) ? !mdl_last : m1_req;
`endif
        ma      = mg ? m1_addr : m0_addr;
        mw      = !mg && m0_we;
        is_ram  = ma < 32'h0001_0000;
        is_disp = (ma & ~32'h3) == 32'h0001_0000;
        mlat    = (is_ram && !mw) ? LAT + 2 : 2;
        widx    = int'(ma[15:2]);
        mrd     = 32'h0;
        if (is_ram) begin
          sched[(cyc+1) % 64].ram_en    = 1'b1;
          sched[(cyc+1) % 64].ram_we    = mw;
          sched[(cyc+1) % 64].ram_addr  = ma[15:2];
          sched[(cyc+1) % 64].ram_wdata = m0_wdata;
          if (mw) mdl_mem[widx] = m0_wdata;
          else if (mdl_mem.exists(widx)) mrd = mdl_mem[widx];
        end else if (is_disp && mw) begin
          sched[(cyc+1) % 64].disp_we   = 1'b1;
          sched[(cyc+1) % 64].disp_data = m0_wdata;
        end
        sched[(cyc+mlat) % 64].ack0  = !mg;
        sched[(cyc+mlat) % 64].ack1  = mg;
        sched[(cyc+mlat) % 64].berr  = !is_ram && !is_disp;
        sched[(cyc+mlat) % 64].rdata = mrd;
        free_at    = cyc + mlat + 1;
        pend_valid = 1'b1;
        pend_g     = mg;
        pend_cyc   = cyc + mlat;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin : cmp
    exp_t e;
    if (!rst_n) begin
      chk("outputs_in_reset", {31'b0, any_out}, 32'h0);
    end else begin
      e = sched[cyc % 64];
      chk("strobes{en,we,dwe,ack0,ack1,err}",
          {26'b0, ram_en, ram_we, disp_we, m0_ack, m1_ack, bus_err},
          {26'b0, e.ram_en, e.ram_we, e.disp_we, e.ack0, e.ack1, e.berr});
      if (e.ram_en)  chk("ram_addr", {18'b0, ram_addr}, {18'b0, e.ram_addr});
      if (e.ram_we)  chk("ram_wdata", ram_wdata, e.ram_wdata);
      if (e.disp_we) chk("disp_data", disp_data, e.disp_data);
      if (e.ack0)    chk("m0_rdata", m0_rdata, e.rdata);
      if (e.ack1)    chk("m1_rdata", m1_rdata, e.rdata);
    end
  end

  // Directed transaction driver; records cycle-1 strobes and ack latency.
  int          t_lat;
  logic [31:0] t_rdata;
  logic        t_err, s_ram_en, s_ram_we, s_disp_we;
  logic [AW-1:0] s_ram_addr;
  logic [31:0] s_disp_data;

  task automatic txn(input bit mst, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit drop_early);
    @(negedge clk);
    if (!mst) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = 1'b1; m1_addr = addr;
    end
    t_lat = 0; t_rdata = '0; t_err = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        s_ram_en = ram_en; s_ram_we = ram_we; s_ram_addr = ram_addr;
        s_disp_we = disp_we; s_disp_data = disp_data;
        if (drop_early) begin m0_req = 1'b0; m1_req = 1'b0; end
      end
      if (mst ? m1_ack : m0_ack) begin
        t_lat = k; t_rdata = mst ? m1_rdata : m0_rdata; t_err = bus_err;
        break;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    if (t_lat == 0) begin
      total++; bad++;
      $display("FAIL ack_timeout: no ack for m%0d addr %h within 20 cycles", mst, addr);
    end
    $display("txn m%0d %s addr=%h wdata=%h rdata=%h lat=%0d err=%0b",
             mst, we ? "wr" : "rd", addr, wdata, t_rdata, t_lat, t_err);
  endtask

  int order [4];
  int n_ack, acks;

  initial begin
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m1_req = 0; m1_addr = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_all_outputs_zero", {31'b0, any_out}, 32'h0);
    #2 rst_n = 1'b1;

    txn(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    chk("wr_ram_en_c1", {31'b0, s_ram_en}, 32'h1);
    chk("wr_ram_we_c1", {31'b0, s_ram_we}, 32'h1);
    chk("wr_ram_addr_c1", {18'b0, s_ram_addr}, 32'h4);
    chk("wr_ack_lat", t_lat, 2);
    chk("wr_no_err", {31'b0, t_err}, 32'h0);

    txn(0, 0, 32'h0000_0010, 32'h0, 0);
    chk("rd_ack_lat", t_lat, LAT + 2);
    chk("rd_rdata", t_rdata, 32'hDEAD_BEEF);

    txn(0, 1, 32'h0001_0000, 32'h0000_00A5, 0);
    chk("disp_we_c1", {31'b0, s_disp_we}, 32'h1);
    chk("disp_data_c1", s_disp_data, 32'h0000_00A5);
    chk("disp_no_ram_en", {31'b0, s_ram_en}, 32'h0);
    chk("disp_wr_lat", t_lat, 2);

    txn(0, 0, 32'h0001_0000, 32'h0, 0);
    chk("disp_rd_lat", t_lat, 2);
    chk("disp_rd_rdata", t_rdata, 32'h0);
    chk("disp_rd_no_err", {31'b0, t_err}, 32'h0);

    txn(0, 1, 32'h0000_FFFF, 32'h1234_5678, 0);
    chk("top_ram_addr", {18'b0, s_ram_addr}, 32'h3FFF);
    txn(0, 0, 32'h0000_FFFC, 32'h0, 0);
    chk("top_rd_rdata", t_rdata, 32'h1234_5678);

    txn(0, 0, 32'h0001_0004, 32'h0, 0);
    chk("unmap1_err", {31'b0, t_err}, 32'h1);
    chk("unmap1_lat", t_lat, 2);
    chk("unmap1_rdata", t_rdata, 32'h0);
    chk("unmap1_no_strobe", {30'b0, s_ram_en, s_disp_we}, 32'h0);

    txn(0, 1, 32'h0002_0000, 32'hFFFF_FFFF, 0);
    chk("unmap2_err", {31'b0, t_err}, 32'h1);
    chk("unmap2_lat", t_lat, 2);
    chk("unmap2_no_strobe", {30'b0, s_ram_en, s_disp_we}, 32'h0);

    txn(0, 0, 32'h0000_0010, 32'h0, 1);
    chk("drop_req_lat", t_lat, LAT + 2);
    chk("drop_req_rdata", t_rdata, 32'hDEAD_BEEF);

    txn(1, 0, 32'h0000_0010, 32'h0, 0);
    chk("m1_rd_lat", t_lat, LAT + 2);
    chk("m1_rd_rdata", t_rdata, 32'hDEAD_BEEF);

    // Both masters held: grant order after an M1 transaction.
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0010;
    m1_req = 1; m1_addr = 32'h0000_FFFC;
    n_ack = 0;
    for (int i = 0; i < 4; i++) order[i] = 9;
    for (int k = 0; k < 60 && n_ack < 4; k++) begin
      @(negedge clk);
      if (m0_ack) begin order[n_ack] = 0; n_ack++; end
      if (m1_ack && n_ack < 4) begin order[n_ack] = 1; n_ack++; end
    end
    m0_req = 0; m1_req = 0;
    $display("txn both-held grants=%0d,%0d,%0d,%0d", order[0], order[1], order[2], order[3]);
`ifdef ARB_CPU_PRIO_EN
    chk("grant0", order[0], 0); chk("grant1", order[1], 0);
    chk("grant2", order[2], 0); chk("grant3", order[3], 0);
`else
    chk("grant0", order[0], 0); chk("grant1", order[1], 1);
    chk("grant2", order[2], 0); chk("grant3", order[3], 1);
`endif

    // Reset in the middle of a RAM read: no ack may follow.
    @(negedge clk);
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = 32'h0000_0010;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0; m0_req = 0;
    #1 chk("midread_reset_outputs", {31'b0, any_out}, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (m0_ack || m1_ack) acks++;
    end
    chk("no_ack_after_reset", acks, 0);
    $display("txn reset mid-read acks_after=%0d", acks);

    txn(0, 0, 32'h0000_FFFC, 32'h0, 0);
    chk("post_reset_lat", t_lat, LAT + 2);
    chk("post_reset_rdata", t_rdata, 32'h1234_5678);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
